// File: rtl/seqgen_pkg.sv
// Shared types for the sequence-job scheduler slice.
package seqgen_pkg;

  localparam int unsigned FP_W = 32;

  typedef struct packed {
    logic [FP_W-1:0] a1;
    logic [FP_W-1:0] d;
    logic [FP_W-1:0] n;
    logic [FP_W-1:0] saddr;
  } seq_job_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/seq_job_fifo.sv
// Synchronous FIFO of job descriptors; clear beats push/pop, no full bypass.
module seq_job_fifo
  import seqgen_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  seq_job_t      i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output seq_job_t      o_data,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  seq_job_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;

  // Storage write; contents need no reset since the count gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/seq_job_scheduler.sv
// Queues arithmetic-sequence jobs and feeds them one at a time to the
// generator, with a per-job watchdog, inter-job gap and soft clear.
module seq_job_scheduler
  import seqgen_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned LVL_W         = $clog2(DEPTH) + 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FP_W-1:0]   cmd_a1,
  input  logic [FP_W-1:0]   cmd_d,
  input  logic [FP_W-1:0]   cmd_n,
  input  logic [FP_W-1:0]   cmd_saddr,
  input  logic              soft_clear,
  output logic              gen_activate,
  output logic [FP_W-1:0]   gen_a1,
  output logic [FP_W-1:0]   gen_d,
  output logic [FP_W-1:0]   gen_n,
  output logic [FP_W-1:0]   gen_saddr,
  input  logic              gen_done,
  output logic              busy,
  output logic              job_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  jobs_completed,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  seq_job_t          w_head;
  seq_job_t          w_cmd;
  seq_job_t          r_cfg;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_zero_len;
  logic              w_timeout;
  logic              w_gap_met;
  logic              w_retire;
  logic              w_wd_abort;
  logic [WD_W-1:0]   r_wdog;
  logic [GAP_W-1:0]  r_gap;
  logic              r_job_done;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_jobs;

  assign w_cmd      = '{a1: cmd_a1, d: cmd_d, n: cmd_n, saddr: cmd_saddr};
  assign w_push     = cmd_valid && !w_full && !soft_clear;
  assign w_zero_len = (w_head.n == '0);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_wdog == WD_LAST);
  assign w_gap_met  = (r_gap >= GAP_LAST);

  seq_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_cmd),
    .i_pop   (w_pop),
    .i_clear (soft_clear),
    .o_data  (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; soft_clear overrides any launch or retirement.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (!soft_clear && !w_empty && !w_zero_len) w_state_nxt = LAUNCH;
      LAUNCH: w_state_nxt = soft_clear ? DRAIN : RUN;
      RUN:    if (soft_clear || gen_done || w_timeout) w_state_nxt = DRAIN;
      DRAIN:  if (w_gap_met && !gen_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output and control decode from the current state.
  always_comb begin
    cmd_ready    = !w_full;
    gen_activate = (r_state == RUN);
    busy         = (r_state != IDLE) || !w_empty;
    w_pop        = (r_state == IDLE) && !soft_clear && !w_empty;
    w_wd_abort   = (r_state == RUN) && !soft_clear && !gen_done && w_timeout;
    w_retire     = ((r_state == RUN) && !soft_clear && (gen_done || w_timeout))
                || (w_pop && w_zero_len);
  end

  // Job config, retirement pulses, watchdog and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg         <= '0;
      r_job_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_jobs        <= '0;
      r_wdog        <= '0;
      r_gap         <= '0;
    end else begin
      if (w_pop) r_cfg <= w_head;
      r_job_done    <= w_retire;
      r_timeout_err <= w_wd_abort;
      if (w_retire) r_jobs <= r_jobs + 1'b1;
      if (r_state == RUN) r_wdog <= r_wdog + 1'b1;
      else                r_wdog <= '0;
      if (r_state == DRAIN) begin
        if (!w_gap_met) r_gap <= r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end
    end
  end

  assign gen_a1         = r_cfg.a1;
  assign gen_d          = r_cfg.d;
  assign gen_n          = r_cfg.n;
  assign gen_saddr      = r_cfg.saddr;
  assign job_done       = r_job_done;
  assign timeout_err    = r_timeout_err;
  assign jobs_completed = r_jobs;

endmodule

// File: tb/tb_seq_job_scheduler.sv
// Directed bench for seq_job_scheduler with a behavioural generator model.
module tb_seq_job_scheduler;

  localparam int unsigned DONE_LAT = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a1 = '0, cmd_d = '0, cmd_n = '0, cmd_saddr = '0;
  logic        soft_clear = 1'b0;
  logic        gen_activate;
  logic [31:0] gen_a1, gen_d, gen_n, gen_saddr;
  logic        gen_done;
  logic        busy, job_done, timeout_err;
  logic [15:0] jobs_completed;
  logic [2:0]  fifo_level;
  logic        gen_hang = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_job_scheduler #(
    .DEPTH(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a1(cmd_a1), .cmd_d(cmd_d), .cmd_n(cmd_n), .cmd_saddr(cmd_saddr),
    .soft_clear(soft_clear),
    .gen_activate(gen_activate),
    .gen_a1(gen_a1), .gen_d(gen_d), .gen_n(gen_n), .gen_saddr(gen_saddr),
    .gen_done(gen_done),
    .busy(busy), .job_done(job_done), .timeout_err(timeout_err),
    .jobs_completed(jobs_completed), .fifo_level(fifo_level)
  );

  function automatic real sp2real(input logic [31:0] b);
    logic [63:0] w;
    if (b[30:23] == 8'd0) w = {b[31], 63'd0};
    else w = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
    return $bitstoreal(w);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] w;
    w = $realtobits(r);
    if (w[62:52] == 11'd0) return {w[63], 31'd0};
    return {w[63], 8'(w[62:52] - 11'd896), w[51:29]};
  endfunction

  // Generator model: done DONE_LAT cycles after activate, held while active.
  logic [31:0] mem [256];
  int unsigned g_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_done <= 1'b0;
      g_cnt    <= 0;
    end else if (gen_activate) begin
      g_cnt <= g_cnt + 1;
      if (!gen_hang && !gen_done && g_cnt == DONE_LAT - 1) begin
        gen_done <= 1'b1;
        for (int unsigned i = 0; i < gen_n; i++)
          mem[8'((gen_saddr >> 2) + i)] = real2sp(sp2real(gen_a1) + real'(i) * sp2real(gen_d));
      end
    end else begin
      gen_done <= 1'b0;
      g_cnt    <= 0;
    end
  end

  // Monitor: pulse counts, activation log, high/low run lengths.
  int jd_cnt = 0, to_cnt = 0, both_cnt = 0, act_cnt = 0;
  int high_len = 0, low_len = 0;
  logic mon_prev = 1'b0, seen_fall = 1'b0;
  logic [31:0] act_log [$];
  int high_log [$];
  int gap_log [$];
  always @(negedge clk) begin
    if (job_done) jd_cnt++;
    if (timeout_err) to_cnt++;
    if (job_done && timeout_err) both_cnt++;
    if (gen_activate && !mon_prev) begin
      act_cnt++;
      act_log.push_back(gen_saddr);
      if (seen_fall) gap_log.push_back(low_len);
      high_len = 0;
    end
    if (!gen_activate && mon_prev) begin
      high_log.push_back(high_len);
      seen_fall = 1'b1;
      low_len = 0;
    end
    if (gen_activate) high_len++; else low_len++;
    mon_prev = gen_activate;
  end

  task automatic drive_cmd(input logic [31:0] a1, d, n, sa);
    cmd_a1 = a1; cmd_d = d; cmd_n = n; cmd_saddr = sa; cmd_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; cmd_valid = 1'b0; soft_clear = 1'b0; gen_hang = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if ({cmd_ready, gen_activate, busy, job_done, timeout_err} !== 5'b10000)
      $display("FAIL reset_flags got %b want 10000", {cmd_ready, gen_activate, busy, job_done, timeout_err});
    else passed++;
    checks++; if (jobs_completed !== 16'd0) $display("FAIL reset_jobs got %0d want 0", jobs_completed); else passed++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else passed++;
    checks++; if ({gen_a1, gen_d, gen_n, gen_saddr} !== 128'd0)
      $display("FAIL reset_cfg got %h want 0", {gen_a1, gen_d, gen_n, gen_saddr});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL post_reset got busy=%b rdy=%b want 0/1", busy, cmd_ready); else passed++;
  endtask

  task automatic test_single();
    logic [31:0] exp_w [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    int base_jd;
    do_reset();
    base_jd = jd_cnt;
    drive_cmd(32'h3F800000, 32'h3F800000, 32'd5, 32'd0);
    @(negedge clk); cmd_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1 || gen_activate !== 1'b0)
      $display("FAIL single_k got lvl=%0d act=%b want 1/0", fifo_level, gen_activate);
    else passed++;
    @(negedge clk);
    checks++; if (gen_a1 !== 32'h3F800000 || gen_n !== 32'd5 || gen_activate !== 1'b0)
      $display("FAIL single_k1 got a1=%h n=%0d act=%b want 3f800000/5/0", gen_a1, gen_n, gen_activate);
    else passed++;
    @(negedge clk);
    checks++; if (gen_activate !== 1'b1) $display("FAIL single_k2_act got %b want 1", gen_activate); else passed++;
    for (int c = 0; c < 100 && jd_cnt == base_jd; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (jd_cnt - base_jd !== 1) $display("FAIL single_jd got %0d want 1", jd_cnt - base_jd); else passed++;
    checks++; if (jobs_completed !== 16'd1) $display("FAIL single_cnt got %0d want 1", jobs_completed); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem[i] !== exp_w[i]) $display("FAIL single_mem%0d got %h want %h", i, mem[i], exp_w[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int base_jd, base_act, base_gap, min_gap, tmo;
    logic saw_full, rdy_full;
    do_reset();
    base_jd = jd_cnt; base_act = act_cnt; base_gap = gap_log.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_cmd(32'h3F800000, 32'h3F800000, 32'(i + 1), 32'(256 + 32 * i));
      tmo = 0;
      while (!cmd_ready && tmo < 100) begin @(negedge clk); tmo++; end
    end
    @(negedge clk);
    drive_cmd(32'h3F800000, 32'h3F800000, 32'd1, 32'h3F0);
    saw_full = 1'b0; rdy_full = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (fifo_level == 3'd4) begin saw_full = 1'b1; rdy_full = cmd_ready; end
      if (saw_full && fifo_level == 3'd3) break;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; if (saw_full !== 1'b1 || rdy_full !== 1'b0)
      $display("FAIL b2b_full_ready got seen=%b rdy=%b want 1/0", saw_full, rdy_full);
    else passed++;
    for (int c = 0; c < 1000 && jd_cnt - base_jd < 5; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++; if (jd_cnt - base_jd !== 5) $display("FAIL b2b_jd got %0d want 5", jd_cnt - base_jd); else passed++;
    checks++; if (jobs_completed !== 16'd5) $display("FAIL b2b_cnt got %0d want 5", jobs_completed); else passed++;
    checks++; if (act_cnt - base_act !== 5) $display("FAIL b2b_acts got %0d want 5", act_cnt - base_act); else passed++;
    for (int i = 0; i < 5 && base_act + i < act_log.size(); i++) begin
      checks++; if (act_log[base_act + i] !== 32'(256 + 32 * i))
        $display("FAIL b2b_order%0d got %h want %h", i, act_log[base_act + i], 32'(256 + 32 * i));
      else passed++;
    end
    min_gap = 1000;
    for (int i = base_gap; i < gap_log.size(); i++) if (gap_log[i] < min_gap) min_gap = gap_log[i];
    checks++; if (min_gap < 2) $display("FAIL b2b_gap got %0d want >=2", min_gap); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_zero_len();
    logic [31:0] exp_w [5] = '{32'h41200000, 32'h41180000, 32'h41100000, 32'h41080000, 32'h41000000};
    int base_jd, base_act;
    do_reset();
    base_jd = jd_cnt; base_act = act_cnt;
    @(negedge clk); drive_cmd(32'h40000000, 32'h3F800000, 32'd0, 32'd400);
    @(negedge clk); drive_cmd(32'h41200000, 32'hBF000000, 32'd5, 32'd20);
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 200 && jd_cnt - base_jd < 2; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if (act_cnt - base_act !== 1) $display("FAIL zero_acts got %0d want 1", act_cnt - base_act); else passed++;
    checks++; if (act_cnt > base_act && act_log[base_act] !== 32'd20)
      $display("FAIL zero_first_act got saddr=%0d want 20", act_log[base_act]);
    else passed++;
    checks++; if (jd_cnt - base_jd !== 2) $display("FAIL zero_jd got %0d want 2", jd_cnt - base_jd); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem[5 + i] !== exp_w[i]) $display("FAIL zero_mem%0d got %h want %h", 5 + i, mem[5 + i], exp_w[i]); else passed++;
    end
  endtask

  task automatic test_timeout();
    int base_jd, base_act, base_to, base_both, base_high;
    do_reset();
    base_jd = jd_cnt; base_act = act_cnt; base_to = to_cnt; base_both = both_cnt; base_high = high_log.size();
    gen_hang = 1'b1;
    @(negedge clk); drive_cmd(32'h3F800000, 32'h3F800000, 32'd3, 32'd160);
    @(negedge clk); drive_cmd(32'h3F800000, 32'h3F800000, 32'd2, 32'd200);
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 300 && high_log.size() == base_high; c++) @(negedge clk);
    gen_hang = 1'b0;
    checks++; if (high_log.size() == base_high) $display("FAIL to_fall got no drop want drop");
    else if (high_log[base_high] !== 50) $display("FAIL to_runlen got %0d want 50", high_log[base_high]);
    else passed++;
    for (int c = 0; c < 300 && jd_cnt - base_jd < 2; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++; if (to_cnt - base_to !== 1 || both_cnt - base_both !== 1)
      $display("FAIL to_pulse got to=%0d both=%0d want 1/1", to_cnt - base_to, both_cnt - base_both);
    else passed++;
    checks++; if (jd_cnt - base_jd !== 2) $display("FAIL to_jd got %0d want 2", jd_cnt - base_jd); else passed++;
    checks++; if (act_cnt - base_act !== 2) $display("FAIL to_acts got %0d want 2", act_cnt - base_act);
    else if (act_log[base_act + 1] !== 32'd200) $display("FAIL to_next got saddr=%0d want 200", act_log[base_act + 1]);
    else passed++;
    checks++; if (jobs_completed !== 16'd2) $display("FAIL to_cnt got %0d want 2", jobs_completed); else passed++;
  endtask

  task automatic test_soft_clear();
    int base_jd, base_act;
    do_reset();
    base_jd = jd_cnt; base_act = act_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_cmd(32'h3F800000, 32'h3F800000, 32'd4, 32'(512 + 32 * i));
    end
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 20 && !gen_activate; c++) @(negedge clk);
    checks++; if (gen_activate !== 1'b1 || fifo_level !== 3'd2)
      $display("FAIL sc_pre got act=%b lvl=%0d want 1/2", gen_activate, fifo_level);
    else passed++;
    soft_clear = 1'b1;
    drive_cmd(32'h3F800000, 32'h3F800000, 32'd1, 32'h3E0);
    @(negedge clk); soft_clear = 1'b0; cmd_valid = 1'b0;
    checks++; if (gen_activate !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL sc_drop got act=%b lvl=%0d want 0/0", gen_activate, fifo_level);
    else passed++;
    repeat (10) @(negedge clk);
    checks++; if (jd_cnt - base_jd !== 0 || jobs_completed !== 16'd0)
      $display("FAIL sc_nodone got jd=%0d cnt=%0d want 0/0", jd_cnt - base_jd, jobs_completed);
    else passed++;
    checks++; if (busy !== 1'b0 || act_cnt - base_act !== 1)
      $display("FAIL sc_idle got busy=%b acts=%0d want 0/1", busy, act_cnt - base_act);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_w [5] = '{32'hC0A00000, 32'hC0200000, 32'h00000000, 32'h40200000, 32'h40A00000};
    int base_jd;
    do_reset();
    @(negedge clk); drive_cmd(32'h3F800000, 32'h3F800000, 32'd5, 32'd600);
    @(negedge clk); drive_cmd(32'h3F800000, 32'h3F800000, 32'd5, 32'd640);
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 20 && !gen_activate; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({gen_activate, busy, job_done, cmd_ready, fifo_level} !== {4'b0001, 3'd0})
      $display("FAIL ar_async got act=%b busy=%b jd=%b rdy=%b lvl=%0d want 0/0/0/1/0",
               gen_activate, busy, job_done, cmd_ready, fifo_level);
    else passed++;
    checks++; if (gen_a1 !== 32'd0 || gen_n !== 32'd0 || jobs_completed !== 16'd0)
      $display("FAIL ar_cfg got a1=%h n=%0d cnt=%0d want 0/0/0", gen_a1, gen_n, jobs_completed);
    else passed++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    base_jd = jd_cnt;
    @(negedge clk); drive_cmd(32'hC0A00000, 32'h40200000, 32'd5, 32'd80);
    @(negedge clk); cmd_valid = 1'b0;
    for (int c = 0; c < 100 && jd_cnt == base_jd; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (jobs_completed !== 16'd1) $display("FAIL ar_cnt got %0d want 1", jobs_completed); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem[20 + i] !== exp_w[i]) $display("FAIL ar_mem%0d got %h want %h", 20 + i, mem[20 + i], exp_w[i]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_len();
    test_timeout();
    test_soft_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
